// File: rtl/rx_packet_parser.sv
// Receive-side packet field splitter. Consumes assembled bytes from the RX shift
// register plus the EOP strobe, checks sync and PID, streams data bytes to the
// RX FIFO and reports packet completion or a sticky framing error.
module rx_packet_parser #(
  parameter logic [7:0]  SYNC_BYTE      = 8'h80,
  parameter int unsigned MAX_DATA_BYTES = 66,
  parameter int unsigned CNT_W          = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             byte_valid,
  input  logic [7:0]       rcv_byte,
  input  logic             eop,
  output logic [3:0]       rx_pid,
  output logic             pid_valid,
  output logic [7:0]       rx_data,
  output logic             data_strobe,
  output logic [CNT_W-1:0] byte_count,
  output logic             packet_done,
  output logic             rx_error,
  output logic             busy
);

  typedef enum logic [2:0] {
    StIdle,
    StPid,
    StData,
    StDone,
    StErr
  } state_e;

  localparam logic [CNT_W-1:0] MaxCount = CNT_W'(MAX_DATA_BYTES);
  localparam logic [CNT_W-1:0] CountOne = CNT_W'(1);

  state_e state_q;
  logic   pid_ok;
  logic   at_max;

  // PID byte carries its own check nibble: upper nibble is the complement of the lower.
  always_comb begin
    pid_ok = (rcv_byte[7:4] == ~rcv_byte[3:0]);
    at_max = (byte_count == MaxCount);
  end

  // Packet FSM; every output is a register updated in the same transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rx_pid      <= 4'h0;
      pid_valid   <= 1'b0;
      rx_data     <= 8'h00;
      data_strobe <= 1'b0;
      byte_count  <= '0;
      packet_done <= 1'b0;
      rx_error    <= 1'b0;
    end else begin
      pid_valid   <= 1'b0;
      data_strobe <= 1'b0;
      packet_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // eop is meaningless before a sync has been seen.
          if (byte_valid) begin
            if (rcv_byte == SYNC_BYTE) begin
              state_q    <= StPid;
              rx_error   <= 1'b0;
              byte_count <= '0;
            end else begin
              state_q  <= StErr;
              rx_error <= 1'b1;
            end
          end
        end
        StPid: begin
          // A PID arriving together with eop is a complete token/handshake packet.
          if (byte_valid) begin
            if (pid_ok) begin
              rx_pid    <= rcv_byte[3:0];
              pid_valid <= 1'b1;
              state_q   <= eop ? StDone : StData;
            end else begin
              state_q  <= StErr;
              rx_error <= 1'b1;
            end
          end else if (eop) begin
            state_q  <= StErr;
            rx_error <= 1'b1;
          end
        end
        StData: begin
          if (byte_valid) begin
            if (at_max) begin
              // Overflow wins over a coincident eop; the count stays at the limit.
              state_q  <= StErr;
              rx_error <= 1'b1;
            end else begin
              rx_data     <= rcv_byte;
              data_strobe <= 1'b1;
              byte_count  <= byte_count + CountOne;
              if (eop) begin
                state_q <= StDone;
              end
            end
          end else if (eop) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          // byte_count is left intact for the controller to read.
          packet_done <= 1'b1;
          state_q     <= StIdle;
        end
        StErr: begin
          if (eop) begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Busy whenever a packet (good or bad) is still being framed.
  always_comb begin
    busy = (state_q != StIdle);
  end

endmodule

// File: tb/tb_rx_packet_parser.sv
// Randomized bench for rx_packet_parser with a packet-position reference model.
module tb_rx_packet_parser;

  localparam int unsigned MaxData = 66;

  logic       clk = 1'b0;
  logic       rst;
  logic       byte_valid;
  logic [7:0] rcv_byte;
  logic       eop;
  logic [3:0] rx_pid;
  logic       pid_valid;
  logic [7:0] rx_data;
  logic       data_strobe;
  logic [6:0] byte_count;
  logic       packet_done;
  logic       rx_error;
  logic       busy;

  always #5 clk = ~clk;

  rx_packet_parser #(
    .SYNC_BYTE     (8'h80),
    .MAX_DATA_BYTES(MaxData),
    .CNT_W         (7)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .byte_valid (byte_valid),
    .rcv_byte   (rcv_byte),
    .eop        (eop),
    .rx_pid     (rx_pid),
    .pid_valid  (pid_valid),
    .rx_data    (rx_data),
    .data_strobe(data_strobe),
    .byte_count (byte_count),
    .packet_done(packet_done),
    .rx_error   (rx_error),
    .busy       (busy)
  );

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: position within the packet (-1 = waiting for sync, 0 = waiting for PID,
  // k >= 1 = k-1 data bytes taken), a framing-error flag and a pending-completion flag.
  int         m_pos;
  bit         m_bad;
  bit         m_closing;
  logic [3:0] e_pid;
  logic       e_pid_valid;
  logic [7:0] e_data;
  logic       e_strobe;
  int         e_count;
  logic       e_done;
  logic       e_err;

  task automatic model(input bit r, input bit v, input logic [7:0] b, input bit e);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = b[7:4];
    lo = b[3:0];
    e_pid_valid = 1'b0;
    e_strobe    = 1'b0;
    e_done      = 1'b0;
    if (r) begin
      m_pos = -1; m_bad = 0; m_closing = 0;
      e_pid = 0; e_data = 0; e_count = 0; e_err = 0;
    end else if (m_closing) begin
      e_done = 1'b1;
      m_closing = 0;
      m_pos = -1;
    end else if (m_bad) begin
      if (e) m_bad = 0;
    end else if (m_pos < 0) begin
      if (v) begin
        if (b == 8'h80) begin
          m_pos = 0; e_err = 0; e_count = 0;
        end else begin
          m_bad = 1; e_err = 1;
        end
      end
    end else if (m_pos == 0) begin
      if (v && ((hi + lo) == 4'hF)) begin
        e_pid = lo; e_pid_valid = 1'b1; m_pos = 1;
        if (e) m_closing = 1;
      end else if (v || e) begin
        m_bad = 1; e_err = 1; m_pos = -1;
      end
    end else begin
      if (v) begin
        if (e_count >= MaxData) begin
          m_bad = 1; e_err = 1; m_pos = -1;
        end else begin
          e_data = b; e_strobe = 1'b1; e_count++; m_pos++;
          if (e) m_closing = 1;
        end
      end else if (e) begin
        m_closing = 1;
      end
    end
  endtask

  task automatic step(input bit r, input bit v, input logic [7:0] b, input bit e);
    rst        = r;
    byte_valid = v;
    rcv_byte   = b;
    eop        = e;
    @(posedge clk);
    model(r, v, b, e);
    #1;
    check_eq("rx_pid", rx_pid, e_pid);
    check_eq("pid_valid", pid_valid, e_pid_valid);
    check_eq("rx_data", rx_data, e_data);
    check_eq("data_strobe", data_strobe, e_strobe);
    check_eq("byte_count", byte_count, e_count);
    check_eq("packet_done", packet_done, e_done);
    check_eq("rx_error", rx_error, e_err);
    check_eq("busy", busy, (m_pos >= 0) || m_bad || m_closing);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0);
  endtask

  logic [7:0] pkt[$];

  // Sends pkt with up to gap idle cycles between bytes; eop rides on the last byte or follows it.
  task automatic send_pkt(input bit eop_last, input int gap);
    for (int i = 0; i < pkt.size(); i++) begin
      if (gap > 0) idle($urandom_range(0, gap));
      step(0, 1, pkt[i], eop_last && (i == pkt.size() - 1));
    end
    if (!eop_last || pkt.size() == 0) begin
      if (gap > 0) idle($urandom_range(0, gap));
      step(0, 0, 8'h00, 1);
    end
  endtask

  initial begin
    logic [3:0] p;
    int         nd;
    rst = 1; byte_valid = 0; rcv_byte = 0; eop = 0;
    step(1, 0, 8'h00, 0);
    step(1, 1, 8'h80, 1);

    // Token packet.
    pkt = '{8'h80, 8'hE1};
    send_pkt(0, 0); idle(2);
    // Data packet.
    pkt = '{8'h80, 8'hC3, 8'h11, 8'h22, 8'h33};
    send_pkt(0, 0); idle(2);
    // Bad sync, then recovery.
    pkt = '{8'h00};
    send_pkt(0, 0);
    pkt = '{8'h80, 8'hD2};
    send_pkt(0, 0); idle(2);
    // Bad PID followed by data bytes.
    pkt = '{8'h80, 8'hC4, 8'h55, 8'h66};
    send_pkt(0, 0); idle(2);
    // Overflow: 67 data bytes.
    pkt = '{8'h80, 8'hC3};
    for (int i = 0; i < 67; i++) pkt.push_back(8'(i + 1));
    send_pkt(0, 0); idle(2);
    // Exactly the maximum with eop on the last byte.
    pkt = '{8'h80, 8'hC3};
    for (int i = 0; i < 66; i++) pkt.push_back(8'($urandom));
    send_pkt(1, 0); idle(2);
    // Last byte together with eop.
    pkt = '{8'h80, 8'hC3, 8'h01, 8'hAA};
    send_pkt(1, 0); idle(2);
    // PID together with eop.
    pkt = '{8'h80, 8'hA5};
    send_pkt(1, 0); idle(2);
    // Reset after two data bytes.
    step(0, 1, 8'h80, 0); step(0, 1, 8'hC3, 0);
    step(0, 1, 8'h12, 0); step(0, 1, 8'h34, 0);
    step(1, 0, 8'h00, 0);
    idle(3);

    // Randomized packets with gaps, stray eops, corruption and resets.
    for (int n = 0; n < 200; n++) begin
      pkt.delete();
      pkt.push_back(($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h80);
      p = 4'($urandom);
      pkt.push_back(($urandom_range(0, 3) == 0) ? 8'($urandom) : {~p, p});
      nd = ($urandom_range(0, 5) == 0) ? $urandom_range(60, 70) : $urandom_range(0, 6);
      for (int i = 0; i < nd; i++) pkt.push_back(8'($urandom));
      if ($urandom_range(0, 9) == 0) pkt = pkt[0:$urandom_range(0, pkt.size() - 1)];
      if ($urandom_range(0, 7) == 0) step(0, 0, 8'h00, 1);
      send_pkt($urandom_range(0, 2) == 0, $urandom_range(0, 2));
      if ($urandom_range(0, 19) == 0) step(1, $urandom_range(0, 1), 8'($urandom), 0);
      idle($urandom_range(0, 2));
    end
    // Reset mid-packet from the random pool as well.
    step(0, 1, 8'h80, 0); step(0, 1, 8'h96, 0); step(0, 1, 8'h5A, 0);
    step(1, 1, 8'h5B, 1);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/rx_packet_parser.md
Name: rx_packet_parser

Overview:
Receive-side counterpart of the transmit byte path. Takes bytes assembled by the RX shift register and splits them by packet field: sync check, PID capture with complement check, data byte streaming to the RX FIFO, and end-of-packet signalling. Sits between the RX shift register/EOP detector and the RX FIFO/protocol controller. Malformed packets raise a sticky error.

Parameters:
SYNC_BYTE, 8'h80, expected sync value as assembled by the RX shift register
MAX_DATA_BYTES, 66, maximum bytes accepted after PID (64 payload + 2 CRC)
CNT_W, 7, width of byte_count; must hold MAX_DATA_BYTES

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
byte_valid  input  1  one-cycle strobe: rcv_byte holds a complete byte
rcv_byte  input  8  byte from RX shift register
eop  input  1  one-cycle strobe: end of packet detected on bus
rx_pid  output  4  last accepted PID (low nibble)
pid_valid  output  1  one-cycle pulse: rx_pid updated
rx_data  output  8  last accepted data byte
data_strobe  output  1  one-cycle pulse: rx_data valid, write to FIFO
byte_count  output  CNT_W  data bytes accepted in current packet
packet_done  output  1  one-cycle pulse: packet closed cleanly
rx_error  output  1  sticky error flag
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset is synchronous and active-high. While rst is high, state = IDLE and all outputs are 0: rx_pid=0, rx_data=0, byte_count=0, rx_error=0, strobes=0.
- All outputs are registered. Each response appears the cycle after the input strobe that causes it.
- States: IDLE, PID, DATA, DONE, ERR.
- IDLE:
  - byte_valid with rcv_byte==SYNC_BYTE -> PID. Clears rx_error and byte_count.
  - byte_valid with any other byte -> ERR. Sets rx_error.
  - eop is ignored.
- PID:
  - byte_valid with rcv_byte[7:4] == ~rcv_byte[3:0] -> latch rx_pid=rcv_byte[3:0], pulse pid_valid, go to DATA.
  - byte_valid failing the complement check -> ERR. rx_pid is not updated.
  - eop -> ERR.
- DATA:
  - byte_valid -> rx_data=rcv_byte, pulse data_strobe, byte_count+1.
  - byte_valid when byte_count==MAX_DATA_BYTES -> ERR. No strobe, count holds.
  - eop -> DONE. Zero-byte packets (token/handshake with PID only) are legal.
- DONE: pulse packet_done for one cycle, then go to IDLE. byte_valid here is ignored.
- ERR:
  - rx_error stays high; byte_valid is ignored; no strobes are issued.
  - eop -> IDLE without packet_done.
  - rx_error is cleared only by reset or by the next accepted sync.
- Simultaneous byte_valid and eop:
  - In DATA: the byte is accepted (data_strobe, count++) and the state goes to DONE in the same transition. packet_done follows one cycle after data_strobe.
  - In PID: the PID is evaluated first. If valid, pid_valid pulses and the state goes to DONE; otherwise ERR.
  - In IDLE: the byte is evaluated and eop is ignored.
- byte_count holds its value after packet_done until the next sync, so the controller can read it.
- rst high mid-packet returns to IDLE next cycle. No packet_done and no strobes are issued.
- busy = (state != IDLE).

Test Plan:
- Token packet: bytes 80, E1 then eop -> pid_valid one cycle with rx_pid=1; packet_done one cycle; byte_count=0; rx_error=0.
- Data packet: 80, C3, 11, 22, 33 then eop -> rx_pid=3; three data_strobes carrying 11, 22, 33; byte_count=3; packet_done one cycle after the last strobe.
- Bad sync then recovery: byte 00 -> rx_error=1, no strobes; eop -> IDLE; then 80, D2, eop -> rx_error clears on sync, rx_pid=2, packet_done.
- Bad PID: 80, C4 -> rx_error=1, no pid_valid, rx_pid unchanged; following data bytes produce no data_strobe.
- Overflow: 80, C3, then 67 data bytes -> 66 data_strobes; 67th sets rx_error; eop gives no packet_done.
- Simultaneous/reset: last data byte AA with eop in the same cycle -> data_strobe (AA), then packet_done next cycle. rst asserted after 2 data bytes -> all outputs 0 and IDLE next cycle, no packet_done.
